// File: rtl/fpu_fp64_to_fp32_pipe_pkg.sv
// Shared FPU definitions for the narrowing converters.
// Holds the binary64/binary32 exponent biases and their difference, the
// all-ones exponent codes, the quiet-NaN marker bit position in a binary32
// fraction, the exception flag bundle and the operand class encoding.
package fpu_fp64_to_fp32_pipe_pkg;

    localparam int FP64_BIAS  = 1023;
    localparam int FP32_BIAS  = 127;
    localparam int BIAS_DELTA = FP64_BIAS - FP32_BIAS;

    localparam logic [10:0] FP64_EXP_ONES = 11'h7FF;
    localparam logic [7:0]  FP32_EXP_ONES = 8'hFF;

    // Fraction bit that marks a binary32 NaN as quiet.
    localparam int QNAN_BIT = 22;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inx;
    } fp_flags_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NAN,
        CLS_NORM
    } fp_class_t;

endpackage

// File: rtl/fpu_rne_round24.sv
// Combinational round-to-nearest-even of a 24-bit significand.
// Ports:
//   m       in  24  significand including the hidden bit
//   g       in   1  guard bit (first bit below m)
//   st      in   1  sticky OR of all remaining lower bits
//   m_rnd   out 24  rounded significand (zero when carry is set)
//   carry   out  1  rounding carried out of 24 bits
//   inexact out  1  some discarded bit was nonzero
module fpu_rne_round24 (
    input  logic [23:0] m,
    input  logic        g,
    input  logic        st,
    output logic [23:0] m_rnd,
    output logic        carry,
    output logic        inexact
);

    logic round_up;

    // A tie (g set, st clear) rounds up only when that makes the lsb even.
    assign round_up = g & (st | m[0]);
    assign {carry, m_rnd} = {1'b0, m} + {24'b0, round_up};
    assign inexact = g | st;

endmodule

// File: rtl/fpu_fp64_to_fp32_pipe.sv
// Two-stage pipelined binary64 -> binary32 converter, round-to-nearest-even.
// Stage 1 classifies the operand, rebiases the exponent and rounds the
// significand; stage 2 applies the rounding carry, picks overflow/underflow
// and packs the result. Denormal inputs and results flush to signed zero.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake, src sampled when both are high
//   src       in  64    binary64 operand
//   out_valid/out_ready output handshake
//   dst       out 32    binary32 result
//   flg_ovf/unf/inx     overflow, underflow (flush), inexact flags
module fpu_fp64_to_fp32_pipe
    import fpu_fp64_to_fp32_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] src,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dst,
    output logic        flg_ovf,
    output logic        flg_unf,
    output logic        flg_inx
);

    logic stall;

    // The whole pipe freezes while an unconsumed result sits at the output.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    logic        s_in;
    logic [10:0] e_in;
    logic [51:0] f_in;

    assign s_in = src[63];
    assign e_in = src[62:52];
    assign f_in = src[51:0];

    fp_class_t         cls_d;
    logic signed [11:0] eb_d;
    logic [22:0]       nan_payload;
    logic [23:0]       m_rnd;
    logic              rnd_carry;
    logic              rnd_inexact;
    logic [23:0]       mant_d;

    always_comb begin
        cls_d = CLS_NORM;
        if (e_in == 11'd0) begin
            cls_d = CLS_ZERO;
        end else if (e_in == FP64_EXP_ONES) begin
            cls_d = (f_in == 52'd0) ? CLS_INF : CLS_NAN;
        end
    end

    // Keeping the top payload bits and forcing the quiet bit guarantees
    // a NaN never degenerates into an infinity encoding.
    always_comb begin
        nan_payload           = f_in[51:29];
        nan_payload[QNAN_BIT] = 1'b1;
    end

    assign eb_d = $signed({1'b0, e_in}) - $signed(12'(BIAS_DELTA));

    fpu_rne_round24 u_round (
        .m       ({1'b1, f_in[51:29]}),
        .g       (f_in[28]),
        .st      (|f_in[27:0]),
        .m_rnd   (m_rnd),
        .carry   (rnd_carry),
        .inexact (rnd_inexact)
    );

    // NaNs reuse the mantissa register to carry their payload to stage 2.
    assign mant_d = (cls_d == CLS_NAN) ? {1'b0, nan_payload} : m_rnd;

    logic               v1;
    fp_class_t          cls1;
    logic               s1;
    logic signed [11:0] eb1;
    logic [23:0]        mant1;
    logic               carry1;
    logic               inx1;

    // Stage 1 register: loads only on an accepted input, holds on stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1     <= 1'b0;
            cls1   <= CLS_ZERO;
            s1     <= 1'b0;
            eb1    <= '0;
            mant1  <= '0;
            carry1 <= 1'b0;
            inx1   <= 1'b0;
        end else if (!stall) begin
            v1 <= in_valid;
            if (in_valid) begin
                cls1   <= cls_d;
                s1     <= s_in;
                eb1    <= eb_d;
                mant1  <= mant_d;
                carry1 <= (cls_d == CLS_NORM) & rnd_carry;
                inx1   <= rnd_inexact;
            end
        end
    end

    // The hidden bit is implicit in the packed binary32 format.
    logic hidden_unused;
    assign hidden_unused = mant1[23];

    logic signed [11:0] eb_adj;
    logic [31:0]        pack_dst;
    fp_flags_t          pack_flags;

    assign eb_adj = eb1 + $signed({11'b0, carry1});

    // Underflow is judged on the pre-round exponent, overflow on the
    // post-round one, so a carry can push a result into infinity but
    // never rescue a value that was already below the normal range.
    always_comb begin
        pack_dst   = {s1, 31'b0};
        pack_flags = '0;
        case (cls1)
            CLS_ZERO: pack_dst = {s1, 31'b0};
            CLS_INF:  pack_dst = {s1, FP32_EXP_ONES, 23'b0};
            CLS_NAN:  pack_dst = {s1, FP32_EXP_ONES, mant1[22:0]};
            default: begin
                if (eb1 <= 12'sd0) begin
                    pack_flags.unf = 1'b1;
                    pack_flags.inx = 1'b1;
                end else if (eb_adj >= $signed({4'b0, FP32_EXP_ONES})) begin
                    pack_dst       = {s1, FP32_EXP_ONES, 23'b0};
                    pack_flags.ovf = 1'b1;
                    pack_flags.inx = 1'b1;
                end else begin
                    pack_dst       = {s1, eb_adj[7:0], mant1[22:0]};
                    pack_flags.inx = inx1;
                end
            end
        endcase
    end

    fp_flags_t flags_q;

    // Stage 2 register: bubbles advance as out_valid=0 without touching dst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            dst       <= '0;
            flags_q   <= '0;
        end else if (!stall) begin
            out_valid <= v1;
            if (v1) begin
                dst     <= pack_dst;
                flags_q <= pack_flags;
            end
        end
    end

    assign flg_ovf = flags_q.ovf;
    assign flg_unf = flags_q.unf;
    assign flg_inx = flags_q.inx;

endmodule

// File: tb/tb_fpu_fp64_to_fp32_pipe.sv
// Self-checking bench for fpu_fp64_to_fp32_pipe: directed vector table,
// backpressure and reset sequences, and randomized traffic scored against
// an integer-arithmetic reference model.
module tb_fpu_fp64_to_fp32_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] src;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dst;
    logic        flg_ovf;
    logic        flg_unf;
    logic        flg_inx;
    logic [2:0]  flags;

    assign flags = {flg_ovf, flg_unf, flg_inx};

    always #5 clk = ~clk;

    fpu_fp64_to_fp32_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src       (src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dst       (dst),
        .flg_ovf   (flg_ovf),
        .flg_unf   (flg_unf),
        .flg_inx   (flg_inx)
    );

    typedef struct {
        logic [63:0] src;
        logic [31:0] dst;
        logic [2:0]  flags;
    } vec_t;

    typedef struct {
        logic [31:0] dst;
        logic [2:0]  flags;
        int          acceptCycle;
    } exp_t;

    exp_t expQ[$];
    vec_t tbl[$];

    int   nChecks = 0;
    int   nFail = 0;
    int   cycleNo = 0;
    int   nOut = 0;
    bit   checkLatency = 1'b0;
    logic prevHold = 1'b0;
    logic [31:0] prevDst = '0;
    logic [2:0]  prevFlags = '0;
    logic lastInReady = 1'b1;

    // Reference conversion using whole-number arithmetic on the 53-bit
    // significand; returns {ovf, unf, inx, dst}.
    function automatic logic [34:0] refConvert(input logic [63:0] x);
        logic              s;
        int                e;
        int                ex;
        longint unsigned   sig;
        longint unsigned   q;
        longint unsigned   rem;
        longint unsigned   half;
        logic [31:0]       r;
        s    = x[63];
        e    = int'(x[62:52]);
        half = 64'd1 << 28;
        if (e == 0) return {3'b000, s, 31'b0};
        if (e == 2047) begin
            if (x[51:0] == 52'd0) return {3'b000, s, 8'hFF, 23'b0};
            r     = {s, 8'hFF, x[51:29]};
            r[22] = 1'b1;
            return {3'b000, r};
        end
        sig = 64'(x[51:0]) | (64'd1 << 52);
        q   = sig >> 29;
        rem = sig & ((64'd1 << 29) - 64'd1);
        ex  = e - 1023 + 127;
        if (ex <= 0) return {3'b011, s, 31'b0};
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
            q  = q >> 1;
            ex = ex + 1;
        end
        if (ex >= 255) return {3'b101, s, 8'hFF, 23'b0};
        r = {s, ex[7:0], q[22:0]};
        return {2'b00, rem != 64'd0, r};
    endfunction

    function automatic logic [63:0] randomSrc();
        logic [63:0] raw;
        logic [51:0] f;
        logic [10:0] e;
        int          k;
        raw = {$urandom(), $urandom()};
        f   = raw[51:0];
        k   = $urandom_range(0, 9);
        case (k)
            0: e = 11'd0;
            1: begin
                e = 11'h7FF;
                if ($urandom_range(0, 1) == 1) f = '0;
            end
            2: e = 11'($urandom_range(890, 900));
            3: begin
                e = 11'($urandom_range(1145, 1151));
                if ($urandom_range(0, 1) == 1) f[51:29] = '1;
            end
            default: e = 11'($urandom_range(897, 1150));
        endcase
        if ($urandom_range(0, 3) == 0) f[28:0] = 29'h1000_0000;
        return {raw[63], e, f};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got !== want) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cycleNo);
        end
    endtask

    // One clock of traffic: drive at the falling edge, then check what the
    // DUT presents and note what the next rising edge will transfer.
    task automatic applyStimulus(input logic iv, input logic [63:0] isrc,
                                 input logic [31:0] edst, input logic [2:0] efl,
                                 input logic ordy, output logic accepted);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        src       = isrc;
        out_ready = ordy;
        #1;
        lastInReady = in_ready;
        checkOutput("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        if (prevHold) begin
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_dst", 64'(dst), 64'(prevDst));
            checkOutput("hold_flags", 64'(flags), 64'(prevFlags));
        end
        if (out_valid && out_ready) begin
            nOut++;
            if (expQ.size() == 0) begin
                nChecks++;
                nFail++;
                $display("[TB] FAIL spurious_out: got dst %h, expected no result", dst);
            end else begin
                e = expQ.pop_front();
                checkOutput("dst", 64'(dst), 64'(e.dst));
                checkOutput("flags", 64'(flags), 64'(e.flags));
                if (checkLatency)
                    checkOutput("latency", 64'(cycleNo - e.acceptCycle), 64'd2);
            end
        end
        prevHold  = out_valid && !out_ready;
        prevDst   = dst;
        prevFlags = flags;
        accepted  = iv && in_ready;
        if (accepted) expQ.push_back('{edst, efl, cycleNo});
        cycleNo++;
    endtask

    task automatic sendOne(input logic [63:0] s, input logic [31:0] d, input logic [2:0] fl);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) applyStimulus(1'b1, s, d, fl, 1'b1, acc);
        if (!acc) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL send_timeout: got no accept, expected accept within 50 cycles");
        end
    endtask

    task automatic drain(input int budget);
        logic acc;
        for (int i = 0; i < budget && expQ.size() != 0; i++)
            applyStimulus(1'b0, 64'd0, 32'd0, 3'd0, 1'b1, acc);
        applyStimulus(1'b0, 64'd0, 32'd0, 3'd0, 1'b1, acc);
        if (expQ.size() != 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        logic        acc;
        logic [63:0] s;
        logic [34:0] r;
        logic [63:0] bpSrc[4];
        int          startOut;
        int          holdLeft;
        int          stallSeen;
        bit          firstSeen;

        tbl.push_back('{64'h3FF0000000000000, 32'h3F800000, 3'b000});
        tbl.push_back('{64'h3FF0000010000000, 32'h3F800000, 3'b001});
        tbl.push_back('{64'h3FF0000030000000, 32'h3F800002, 3'b001});
        tbl.push_back('{64'h3FF0000018000000, 32'h3F800001, 3'b001});
        tbl.push_back('{64'h47EFFFFFF0000000, 32'h7F800000, 3'b101});
        tbl.push_back('{64'h47F0000000000000, 32'h7F800000, 3'b101});
        tbl.push_back('{64'h47EFFFFFE0000000, 32'h7F7FFFFF, 3'b000});
        tbl.push_back('{64'h3800000000000000, 32'h00000000, 3'b011});
        tbl.push_back('{64'h380FFFFFF0000000, 32'h00000000, 3'b011});
        tbl.push_back('{64'h3810000000000000, 32'h00800000, 3'b000});
        tbl.push_back('{64'hFFF0000000000000, 32'hFF800000, 3'b000});
        tbl.push_back('{64'h7FF0000000000001, 32'h7FC00000, 3'b000});
        tbl.push_back('{64'h7FF8000000000000, 32'h7FC00000, 3'b000});
        tbl.push_back('{64'h0000000000000001, 32'h00000000, 3'b000});
        tbl.push_back('{64'h8000000000000000, 32'h80000000, 3'b000});
        tbl.push_back('{64'hBFF0000000000000, 32'hBF800000, 3'b000});

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        src       = '0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_dst", 64'(dst), 64'd0);
        checkOutput("reset_flags", 64'(flags), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] directed vector table");
        checkLatency = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            sendOne(tbl[i].src, tbl[i].dst, tbl[i].flags);
            drain(10);
        end

        $display("[TB] backpressure sequence");
        checkLatency = 1'b0;
        bpSrc[0] = 64'h3FF0000000000000;
        bpSrc[1] = 64'h4000000000000000;
        bpSrc[2] = 64'hC008000000000000;
        bpSrc[3] = 64'h3FF0000030000000;
        startOut  = nOut;
        holdLeft  = 3;
        stallSeen = 0;
        firstSeen = 1'b0;
        for (int k = 0, step = 0; step < 40 && (k < 4 || expQ.size() != 0); step++) begin
            logic ordy;
            bit   holding;
            holding = firstSeen && holdLeft > 0;
            ordy    = !holding;
            if (holding) holdLeft--;
            if (k < 4) begin
                r = refConvert(bpSrc[k]);
                applyStimulus(1'b1, bpSrc[k], r[31:0], r[34:32], ordy, acc);
                if (acc) k++;
            end else begin
                applyStimulus(1'b0, 64'd0, 32'd0, 3'd0, ordy, acc);
            end
            if (holding && !lastInReady) stallSeen++;
            if (nOut > startOut) firstSeen = 1'b1;
        end
        checkOutput("bp_stall_cycles", 64'(stallSeen), 64'd3);
        drain(20);
        checkOutput("bp_result_count", 64'(nOut - startOut), 64'd4);

        $display("[TB] reset with results in flight");
        checkLatency = 1'b1;
        sendOne(64'h3FF0000000000000, 32'h3F800000, 3'b000);
        sendOne(64'hBFF0000000000000, 32'hBF800000, 3'b000);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        checkOutput("midreset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midreset_dst", 64'(dst), 64'd0);
        expQ.delete();
        prevHold = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        startOut = nOut;
        sendOne(64'h4000000000000000, 32'h40000000, 3'b000);
        drain(10);
        repeat (3) applyStimulus(1'b0, 64'd0, 32'd0, 3'd0, 1'b1, acc);
        checkOutput("post_reset_count", 64'(nOut - startOut), 64'd1);

        $display("[TB] randomized traffic");
        checkLatency = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic iv;
            logic ordy;
            s    = randomSrc();
            r    = refConvert(s);
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            applyStimulus(iv, s, r[31:0], r[34:32], ordy, acc);
        end
        drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no completion, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
